// File: rtl/tft_cmd_queue.sv
// Init sequencer plus rectangle-command FIFO in front of the ILI9341 SPI controller.
// Optional pop-time clipping when TFT_CMD_QUEUE_CLIP_EN is defined.
module tft_cmd_queue #(
  parameter int DEPTH_LOG2 = 3,
  parameter int XMAX       = 239,
  parameter int YMAX       = 319
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [15:0]           cmd_color,
  input  logic [15:0]           cmd_x0,
  input  logic [15:0]           cmd_x1,
  input  logic [15:0]           cmd_y0,
  input  logic [15:0]           cmd_y1,
  output logic                  tft_init,
  output logic                  tft_draw,
  input  logic                  tft_busy,
  input  logic                  tft_done,
  output logic [15:0]           tft_color,
  output logic [15:0]           tft_xstart,
  output logic [15:0]           tft_xend,
  output logic [15:0]           tft_ystart,
  output logic [15:0]           tft_yend,
  output logic                  ready_init,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 6 || XMAX > 65535 || YMAX > 65535)
  begin : g_bad_param
    $error("tft_cmd_queue: illegal parameter");
  end

  typedef enum logic [2:0] {
    BOOT, INIT_REQ, INIT_WAIT, GAP,
    IDLE, CLIP, DRAW_REQ, DRAW_WAIT
  } state_t;

  state_t state;

  logic [79:0]         mem [DEPTH];
  logic [DEPTH_LOG2:0] wptr, rptr;
  logic [DEPTH_LOG2:0] wptr_n, rptr_n;
  logic                push, pop, empty;
  logic [15:0]         h_col, h_x0, h_x1, h_y0, h_y1;
  logic [15:0]         c_x1, c_y1;
  logic                drop;
  state_t              after_pop;

  assign empty = (wptr == rptr);
  assign push  = cmd_valid & cmd_ready;
  assign pop   = (state == IDLE) & ~empty;

  assign {h_col, h_x0, h_x1, h_y0, h_y1} = mem[rptr[DEPTH_LOG2-1:0]];

`ifdef TFT_CMD_QUEUE_CLIP_EN
  localparam logic [15:0] XLIM = 16'(XMAX);
  localparam logic [15:0] YLIM = 16'(YMAX);

  assign c_x1 = (h_x1 > XLIM) ? XLIM : h_x1;
  assign c_y1 = (h_y1 > YLIM) ? YLIM : h_y1;
  assign drop = (h_x0 > h_x1) | (h_y0 > h_y1) |
                (h_x0 > XLIM) | (h_y0 > YLIM);
  assign after_pop = CLIP;
`else
  assign c_x1 = h_x1;
  assign c_y1 = h_y1;
  assign drop = 1'b0;
  assign after_pop = DRAW_REQ;
`endif

  always_comb begin
    wptr_n = wptr + {{DEPTH_LOG2{1'b0}}, push};
    rptr_n = rptr + {{DEPTH_LOG2{1'b0}}, pop};
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wptr[DEPTH_LOG2-1:0]] <=
        {cmd_color, cmd_x0, cmd_x1, cmd_y0, cmd_y1};
  end

  // full = pointers differ only in the wrap bit
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      cmd_ready <= 1'b1;
      overflow  <= 1'b0;
    end else begin
      wptr      <= wptr_n;
      rptr      <= rptr_n;
      level     <= wptr_n - rptr_n;
      cmd_ready <= ((wptr_n ^ rptr_n) !=
                    {1'b1, {DEPTH_LOG2{1'b0}}});
      overflow  <= overflow | (cmd_valid & ~cmd_ready);
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state      <= BOOT;
      tft_init   <= 1'b0;
      tft_draw   <= 1'b0;
      ready_init <= 1'b0;
      tft_color  <= '0;
      tft_xstart <= '0;
      tft_xend   <= '0;
      tft_ystart <= '0;
      tft_yend   <= '0;
    end else begin
      unique case (state)
        BOOT: state <= INIT_REQ;
        INIT_REQ: begin
          if (tft_busy) begin
            tft_init <= 1'b0;
            state    <= INIT_WAIT;
          end else begin
            tft_init <= 1'b1;
          end
        end
        INIT_WAIT: begin
          if (tft_done) begin
            ready_init <= 1'b1;
            state      <= GAP;
          end
        end
        GAP: state <= IDLE;
        IDLE: begin
          if (pop && !drop) begin
            tft_color  <= h_col;
            tft_xstart <= h_x0;
            tft_xend   <= c_x1;
            tft_ystart <= h_y0;
            tft_yend   <= c_y1;
            state      <= after_pop;
          end
        end
        CLIP: state <= DRAW_REQ;
        DRAW_REQ: begin
          if (tft_busy) begin
            tft_draw <= 1'b0;
            state    <= DRAW_WAIT;
          end else begin
            tft_draw <= 1'b1;
          end
        end
        DRAW_WAIT: begin
          if (tft_done)
            state <= GAP;
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_tft_cmd_queue.sv
// Self-checking bench for tft_cmd_queue: vector table, draw scoreboard,
// and a controller model answering busy after 1 cycle, done after 20.
module tb_tft_cmd_queue;

`ifdef TFT_CMD_QUEUE_CLIP_EN
  localparam int LAT  = 3;
  localparam bit CLIP = 1'b1;
`else
  localparam int LAT  = 2;
  localparam bit CLIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        arstn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_color = '0, cmd_x0 = '0, cmd_x1 = '0;
  logic [15:0] cmd_y0 = '0, cmd_y1 = '0;
  logic        tft_init, tft_draw;
  logic        tft_busy, tft_done;
  logic [15:0] tft_color, tft_xstart, tft_xend;
  logic [15:0] tft_ystart, tft_yend;
  logic        ready_init;
  logic [3:0]  level;
  logic        overflow;
  logic        stall = 1'b1;

  tft_cmd_queue dut (
    .clk(clk), .arstn(arstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_color(cmd_color), .cmd_x0(cmd_x0), .cmd_x1(cmd_x1),
    .cmd_y0(cmd_y0), .cmd_y1(cmd_y1),
    .tft_init(tft_init), .tft_draw(tft_draw),
    .tft_busy(tft_busy), .tft_done(tft_done),
    .tft_color(tft_color), .tft_xstart(tft_xstart),
    .tft_xend(tft_xend), .tft_ystart(tft_ystart),
    .tft_yend(tft_yend), .ready_init(ready_init),
    .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cnt;
  always @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      tft_busy <= 1'b0;
      tft_done <= 1'b0;
      cnt      <= 0;
    end else begin
      tft_done <= 1'b0;
      if (tft_busy) begin
        if (cnt == 1) begin
          tft_busy <= 1'b0;
          tft_done <= 1'b1;
        end
        cnt <= cnt - 1;
      end else if ((tft_init | tft_draw) && !stall && !tft_done) begin
        tft_busy <= 1'b1;
        cnt      <= 20;
      end
    end
  end

  typedef struct {
    logic [15:0] color, x0, x1, y0, y1;
    bit          draw;
    logic [15:0] xend, yend;
    int          lvl;
  } vec_t;

  vec_t        tbl[11];
  logic [79:0] sb[$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string nm, input logic [79:0] act,
                     input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  logic        prev_draw = 1'b0, prev_busy = 1'b0, in_draw = 1'b0;
  logic [79:0] cap, ex;
  int          ndraw = 0, cyc = 0, done_cyc = -100;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (!arstn) begin
      prev_draw = 1'b0;
      prev_busy = 1'b0;
      in_draw   = 1'b0;
    end else begin
      if (prev_draw && prev_busy)
        chk("draw_drop_on_busy", tft_draw, 0);
      if (tft_draw && !prev_draw) begin
        ndraw++;
        in_draw = 1'b1;
        cap = {tft_color, tft_xstart, tft_xend, tft_ystart, tft_yend};
        chk("gap_after_done", (cyc - done_cyc) >= 2, 1);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_draw: got %0h expected none", cap);
        end else begin
          ex = sb.pop_front();
          chk("draw_fields", cap, ex);
        end
      end
      if (tft_done && in_draw) begin
        chk("fields_held",
            {tft_color, tft_xstart, tft_xend, tft_ystart, tft_yend}, cap);
        in_draw = 1'b0;
      end
      if (tft_done) done_cyc = cyc;
      prev_draw = tft_draw;
      prev_busy = tft_busy;
    end
  end

  task automatic push(input int i);
    bit rdy;
    @(negedge clk);
    cmd_color = tbl[i].color;
    cmd_x0    = tbl[i].x0;
    cmd_x1    = tbl[i].x1;
    cmd_y0    = tbl[i].y0;
    cmd_y1    = tbl[i].y1;
    cmd_valid = 1'b1;
    rdy       = cmd_ready;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    if (rdy && tbl[i].draw)
      sb.push_back({tbl[i].color, tbl[i].x0, tbl[i].xend,
                    tbl[i].y0, tbl[i].yend});
  endtask

  task automatic drain(input int bound);
    int n = 0, quiet = 0;
    while (quiet < 4 && n < bound) begin
      @(posedge clk);
      #2;
      n++;
      if (ready_init && sb.size() == 0 && level == 0 &&
          !in_draw && !tft_draw && !tft_busy)
        quiet++;
      else
        quiet = 0;
    end
    chk("drain_in_time", n < bound, 1);
  endtask

  task automatic check_reset();
    chk("rst_init", tft_init, 0);
    chk("rst_draw", tft_draw, 0);
    chk("rst_ready_init", ready_init, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_level", level, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_fields",
        {tft_color, tft_xstart, tft_xend, tft_ystart, tft_yend}, 0);
  endtask

  initial begin
    int n, k, hi, n0;
    bit done_seen;

    for (int i = 0; i < 8; i++) begin
      tbl[i].color = 16'(16'h1111 * (i + 1));
      tbl[i].x0    = 16'(i * 10);
      tbl[i].x1    = 16'(i * 10 + 5);
      tbl[i].y0    = 16'(i);
      tbl[i].y1    = 16'(i + 3);
      tbl[i].draw  = 1'b1;
      tbl[i].xend  = tbl[i].x1;
      tbl[i].yend  = tbl[i].y1;
      tbl[i].lvl   = i + 1;
    end
    tbl[7].x1 = 16'd239; tbl[7].xend = 16'd239;
    tbl[7].y1 = 16'd319; tbl[7].yend = 16'd319;
    tbl[8]  = '{16'h07E0, 16'd100, 16'd400, 16'd0, 16'd50,
                1'b1, CLIP ? 16'd239 : 16'd400, 16'd50, 1};
    tbl[9]  = '{16'h001F, 16'd30, 16'd10, 16'd7, 16'd8,
                !CLIP, 16'd10, 16'd8, 1};
    tbl[10] = '{16'hF800, 16'd10, 16'd20, 16'd5, 16'd6,
                1'b1, 16'd20, 16'd6, 1};

    repeat (3) @(posedge clk);
    #1;
    check_reset();

    // controller stalled: FSM parks in INIT_REQ, FIFO fills
    @(negedge clk);
    arstn = 1'b1;
    @(posedge clk); #1;
    chk("init_not_yet", tft_init, 0);
    @(posedge clk); #1;
    chk("init_rise_2", tft_init, 1);
    for (int i = 0; i < 8; i++) begin
      push(i);
      chk("fill_level", level, tbl[i].lvl);
    end
    chk("full_ready_low", cmd_ready, 0);
    chk("no_overflow_yet", overflow, 0);
    push(8);
    chk("overflow_set", overflow, 1);
    chk("level_full", level, 8);

    stall = 1'b0;
    drain(2000);
    chk("eight_draws", ndraw, 8);
    chk("overflow_sticky", overflow, 1);

    // pop-to-draw latency into an idle, empty queue
    push(10);
    k = 0;
    while (!tft_draw && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    chk("draw_latency", k, LAT);
    drain(200);

    // clamp case, then a reversed rectangle
    push(8);
    drain(200);
    n0 = ndraw;
    push(9);
    chk("bad_rect_level1", level, 1);
    @(posedge clk); #1;
    chk("bad_rect_popped", level, 0);
    repeat (6) @(posedge clk);
    #2;
    chk("bad_rect_draws", ndraw - n0, tbl[9].draw);
    drain(200);

    n0 = ndraw;
    for (int i = 0; i < 4; i++) push(i);
    drain(500);
    chk("four_draws", ndraw - n0, 4);

    // reset in DRAW_WAIT with three entries still queued
    for (int i = 0; i < 4; i++) push(i);
    n = 0;
    while (!(tft_busy && !tft_draw) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reached_draw_wait", n < 100, 1);
    chk("queued_three", level, 3);
    @(negedge clk);
    arstn = 1'b0;
    #1;
    sb.delete();
    check_reset();
    repeat (2) @(posedge clk);

    @(negedge clk);
    arstn = 1'b1;
    @(posedge clk); #1;
    chk("reinit_not_yet", tft_init, 0);
    @(posedge clk); #1;
    chk("reinit_rise_2", tft_init, 1);
    hi = 1;
    n = 0;
    done_seen = 1'b0;
    while (!done_seen && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (tft_init) hi++;
      if (tft_done) done_seen = 1'b1;
    end
    chk("init_done_seen", done_seen, 1);
    chk("ready_at_done", ready_init, 0);
    @(posedge clk); #1;
    chk("ready_after_done", ready_init, 1);
    chk("init_high_cycles", hi, 2);
    chk("level_after_init", level, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
